// File: rtl/mouse_tracker_pkg.sv
// mouse_tracker_pkg: screen geometry, PS/2 status-byte bit positions, packet FSM states and clamp helper.
package mouse_tracker_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int STAT_L = 0;
    localparam int STAT_R = 1;
    localparam int STAT_SYNC = 3;
    localparam int STAT_XS = 4;
    localparam int STAT_YS = 5;
    localparam int STAT_XO = 6;
    localparam int STAT_YO = 7;
    localparam logic [1:0] WAIT_B0 = 2'd0;
    localparam logic [1:0] WAIT_B1 = 2'd1;
    localparam logic [1:0] WAIT_B2 = 2'd2;
    typedef struct packed {
        logic yo;
        logic xo;
        logic ys;
        logic xs;
        logic r;
        logic l;
    } status_t;
    function automatic logic [9:0] clamp(input logic signed [11:0] v, input int hi);
        return v < 0 ? 10'd0 : v > hi ? 10'(hi) : v[9:0];
    endfunction
endpackage

// File: rtl/mouse_tracker_ps2_rx.sv
// ps2_rx: synchronizes and glitch-filters the PS/2 lines and receives 11-bit frames.
// A frame that stalls mid-way for TIMEOUT_CYCLES is dropped and reported on frame_err.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [1:0] s1, s2, f;
    logic [FW-1:0] fcnt [2];
    logic f_clk_d;
    logic [3:0] bcnt;
    logic [9:0] sh;
    logic [TW-1:0] tcnt;
    logic fall, good;
    logic [10:0] frame;
    assign fall = f_clk_d & ~f[0];
    assign frame = {f[1], sh};
    assign good = ~frame[0] & (^frame[9:1]) & frame[10];
    assign rx_busy = bcnt != 4'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
            f <= '1;
            fcnt <= '{default: '0};
            f_clk_d <= 1'b1;
            bcnt <= '0;
            sh <= '0;
            tcnt <= '0;
            rx_byte <= '0;
            byte_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            s1 <= {ps2_data, ps2_clk};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= (s2[i] != f[i] && fcnt[i] != FW'(FILTER_LEN - 1)) ? fcnt[i] + 1'b1 : '0;
                if (s2[i] != f[i] && fcnt[i] == FW'(FILTER_LEN - 1)) f[i] <= s2[i];
            end
            f_clk_d <= f[0];
            byte_valid <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                sh <= frame[10:1];
                bcnt <= bcnt == 4'd10 ? 4'd0 : bcnt + 4'd1;
                if (bcnt == 4'd10) begin
                    rx_byte <= frame[8:1];
                    byte_valid <= good;
                    frame_err <= ~good;
                end
            end else if (rx_busy) begin
                tcnt <= tcnt == TW'(TIMEOUT_CYCLES - 1) ? '0 : tcnt + 1'b1;
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bcnt <= '0;
                    frame_err <= 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end
endmodule

// File: rtl/mouse_tracker.sv
// mouse_tracker: assembles 3-byte PS/2 mouse packets into a screen-clamped absolute cursor and buttons.
module mouse_tracker
    import mouse_tracker_pkg::*;
#(
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic       btn_left,
    output logic       btn_right,
    output logic       pkt_valid,
    output logic       rx_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [7:0] rx_byte, x_byte;
    logic byte_valid, frame_err, rx_busy;
    logic [1:0] state;
    status_t stat;
    logic [TW-1:0] tcnt;
    logic pkt_idle, timeout, err;
    logic signed [11:0] dx, dy, nx, ny;
    ps2_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte(rx_byte),
        .byte_valid(byte_valid),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );
    // Between bytes of a packet the receiver is idle, so the packet timeout runs here.
    assign pkt_idle = state != WAIT_B0 && !rx_busy && !byte_valid;
    assign timeout = pkt_idle && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign err = frame_err | timeout;
    assign dx = stat.xo ? 12'sd0 : $signed({{4{stat.xs}}, x_byte});
    assign dy = stat.yo ? 12'sd0 : $signed({{4{stat.ys}}, rx_byte});
    assign nx = $signed({2'b00, mouse_x}) + dx;
    assign ny = $signed({2'b00, mouse_y}) - dy;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_B0;
            stat <= '0;
            x_byte <= '0;
            tcnt <= '0;
            mouse_x <= 10'(X_INIT);
            mouse_y <= 10'(Y_INIT);
            btn_left <= 1'b0;
            btn_right <= 1'b0;
            pkt_valid <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            tcnt <= pkt_idle && !timeout ? tcnt + 1'b1 : '0;
            rx_err <= err;
            pkt_valid <= 1'b0;
            if (err) begin
                state <= WAIT_B0;
            end else if (byte_valid) begin
                case (state)
                    WAIT_B0: if (rx_byte[STAT_SYNC]) begin
                        stat <= '{yo: rx_byte[STAT_YO], xo: rx_byte[STAT_XO], ys: rx_byte[STAT_YS],
                                  xs: rx_byte[STAT_XS], r: rx_byte[STAT_R], l: rx_byte[STAT_L]};
                        state <= WAIT_B1;
                    end
                    WAIT_B1: begin
                        x_byte <= rx_byte;
                        state <= WAIT_B2;
                    end
                    WAIT_B2: begin
                        mouse_x <= clamp(nx, SCREEN_W - 1);
                        mouse_y <= clamp(ny, SCREEN_H - 1);
                        btn_left <= stat.l;
                        btn_right <= stat.r;
                        pkt_valid <= 1'b1;
                        state <= WAIT_B0;
                    end
                    default: state <= WAIT_B0;
                endcase
            end
        end
    end
endmodule
